race_datapath: RTL

Datapath for the car-race FSM controller: it executes the controller's one-hot drawing commands and returns the `counterx`/`countery` scan counters the controller uses to sequence its states. It keeps the car's column position, turns counter values into registered pixel writes (x, y, colour, plot) for the 160x120 VGA adapter, and clips anything off-screen.

---
 rtl/race_pkg.sv | 31 +++
 rtl/race_xy_counter.sv | 26 ++
 rtl/race_datapath.sv | 125 ++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared constants and phase encoding for the car-race datapath
package race_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int ROAD_L    = 30;
    localparam int ROAD_R    = 130;
    localparam int CAR_W     = 5;
    localparam int CAR_Y     = 100;
    localparam int STEP      = 4;
    localparam int CAR_X_RST = 78;

    // Car's left column is limited so all CAR_W columns stay on the road
    localparam logic [7:0] CAR_X_MIN = 8'(ROAD_L);
    localparam logic [7:0] CAR_X_MAX = 8'(ROAD_R - CAR_W);

    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_GREEN_L,
        PH_BLACK,
        PH_GREEN_R,
        PH_CAR,
        PH_ERASE,
        PH_UPDATE
    } phase_t;

endpackage

// File: rtl/race_xy_counter.sv
// rtl/race_xy_counter.sv - column/row scan counter for one drawing phase
module race_xy_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       inc,
    output logic [7:0] counterx,
    output logic [7:0] countery
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            counterx <= 8'd0;
            countery <= 8'd0;
        end else if (enable) begin
            if (inc) begin
                counterx <= 8'd0;
                countery <= countery + 8'd1;
            end else begin
                counterx <= counterx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/race_datapath.sv
// rtl/race_datapath.sv - drawing datapath: phase tracking, car position, pixel pipeline
module race_datapath
    import race_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       draw_bg_green_left,
    input  logic       draw_bg_black,
    input  logic       draw_bg_green_right,
    input  logic       draw_car,
    input  logic       erase,
    input  logic       update_car,
    input  logic       inc,
    input  logic       left,
    input  logic       right,
    output logic [7:0] counterx,
    output logic [7:0] countery,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    phase_t     active;
    phase_t     phase_q;
    logic       start;
    logic       run;
    logic [7:0] car_x;
    logic [7:0] car_next;
    logic [8:0] car_mv;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] base_col;
    logic [8:0] px;
    logic [8:0] py;
    logic       visible;

    always_comb begin
        active = PH_IDLE;
        if (erase)                    active = PH_ERASE;
        else if (update_car)          active = PH_UPDATE;
        else if (draw_car)            active = PH_CAR;
        else if (draw_bg_black)       active = PH_BLACK;
        else if (draw_bg_green_left)  active = PH_GREEN_L;
        else if (draw_bg_green_right) active = PH_GREEN_R;
    end

    // A change of phase spends one cycle restarting the scan without plotting
    assign start = (active != PH_IDLE) && (active != phase_q);
    assign run   = (active != PH_IDLE) && (active == phase_q);

    always_comb begin
        car_mv = {1'b0, car_x};
        if (left && !right)
            car_mv = {1'b0, car_x} - 9'(STEP);
        else if (right && !left)
            car_mv = {1'b0, car_x} + 9'(STEP);
        car_next = car_mv[7:0];
        if (car_mv < {1'b0, CAR_X_MIN})
            car_next = CAR_X_MIN;
        else if (car_mv > {1'b0, CAR_X_MAX})
            car_next = CAR_X_MAX;
    end

    always_comb begin
        base_x   = 8'd0;
        base_y   = 7'd0;
        base_col = BLACK;
        case (active)
            PH_GREEN_L: base_col = GREEN;
            PH_BLACK:   base_x = 8'(ROAD_L);
            PH_GREEN_R: begin
                base_x   = 8'(ROAD_R);
                base_col = GREEN;
            end
            PH_CAR, PH_UPDATE: begin
                base_x   = car_x;
                base_y   = 7'(CAR_Y);
                base_col = RED;
            end
            PH_ERASE: begin
                base_x = car_x;
                base_y = 7'(CAR_Y);
            end
            default: ;
        endcase
    end

    // Sums are kept one bit wider so off-screen pixels are clipped, not wrapped on-screen
    assign px      = {1'b0, base_x} + {1'b0, counterx};
    assign py      = {2'b00, base_y} + {1'b0, countery};
    assign visible = (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            car_x   <= 8'(CAR_X_RST);
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
        end else begin
            phase_q <= active;
            plot    <= run && visible;
            if (start && (active == PH_UPDATE))
                car_x <= car_next;
            if (run) begin
                x      <= px[7:0];
                y      <= py[6:0];
                colour <= base_col;
            end
        end
    end

    race_xy_counter u_xy_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .enable   (run),
        .inc      (inc),
        .counterx (counterx),
        .countery (countery)
    );

endmodule
